oven_heat_ctrl: RTL

Downstream consumer of the oven's target-temperature entry stage. Takes the 10-bit target temperature produced by the entry stage and simulates the oven cavity temperature under a three-state heater controller: preheat ramp, hysteresis hold, and passive cooling. Drives heater and at-temperature status plus three BCD digits of the current temperature for the seven-segment display stage.

---
 rtl/oven_heat_ctrl_pkg.sv | 17 +
 rtl/oven_heat_ctrl_bin2bcd_seq.sv | 53 +++++
 rtl/oven_heat_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/oven_heat_ctrl_pkg.sv
// Shared oven definitions: controller states, temperature type and the
// default ambient/maximum constants also used by the entry and display stages.
package oven_heat_ctrl_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PREHEAT, ST_HOLD} oven_state_e;

   typedef logic [9:0] temp_t;

   localparam int AMBIENT_DEF  = 70;
   localparam int MAX_TEMP_DEF = 550;

   // Constant-only helper: packs a 0..999 value as three BCD digits.
   function automatic logic [11:0] bcd_of(input int v);
      bcd_of = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/oven_heat_ctrl_bin2bcd_seq.sv
// Iterative double-dabble: 10-bit binary to three BCD digits, one load cycle
// followed by ten shift cycles; done pulses once the digits are final.
module bin2bcd_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [9:0] bin,
   output logic [3:0] bcd2,
   output logic [3:0] bcd1,
   output logic [3:0] bcd0,
   output logic       done
);

   logic [9:0]  bin_q;
   logic [11:0] bcd_q;
   logic [11:0] adj;
   logic [3:0]  cnt_q;
   logic        done_q;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (load) begin
         bin_q  <= bin;
         bcd_q  <= '0;
         cnt_q  <= 4'd10;
         done_q <= 1'b0;
      end else if (cnt_q != 4'd0) begin
         bcd_q  <= {adj[10:0], bin_q[9]};
         bin_q  <= {bin_q[8:0], 1'b0};
         cnt_q  <= cnt_q - 4'd1;
         done_q <= (cnt_q == 4'd1);
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bcd2 = bcd_q[11:8];
   assign bcd1 = bcd_q[7:4];
   assign bcd0 = bcd_q[3:0];
   assign done = done_q;

endmodule

// File: rtl/oven_heat_ctrl.sv
// Oven cavity simulator: preheat ramp, hysteresis hold and passive cooling,
// with registered status and atomically updated BCD digits of the temperature.
module oven_heat_ctrl
   import oven_heat_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int RAMP_UP   = 5,
   parameter int RAMP_DOWN = 2,
   parameter int AMBIENT   = AMBIENT_DEF,
   parameter int MAX_TEMP  = MAX_TEMP_DEF,
   parameter int HYST      = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] target_temp,
   input  logic       start,
   input  logic       stop,
   output logic [9:0] cur_temp,
   output logic       heating,
   output logic       at_temp,
   output logic [3:0] cur_hex0,
   output logic [3:0] cur_hex1,
   output logic [3:0] cur_hex2
);

   localparam int              CW      = $clog2(TICK_DIV);
   localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [10:0]     AMB     = 11'(AMBIENT);
   localparam logic [10:0]     TMAX    = 11'(MAX_TEMP);
   localparam logic [10:0]     RU      = 11'(RAMP_UP);
   localparam logic [10:0]     RD      = 11'(RAMP_DOWN);
   localparam logic [10:0]     HY      = 11'(HYST);
   localparam logic [11:0]     AMB_BCD = bcd_of(AMBIENT);

   oven_state_e   state_q, state_d;
   temp_t         cur_q, cur_d, tgt_q, tgt_d;
   logic [CW-1:0] cnt_q;
   logic          heat_q, at_q, tick;
   logic [11:0]   hex_q;
   logic [10:0]   cur_w, tin_w, tgt_w, nxt_w;
   logic [3:0]    d2, d1, d0;
   logic          bcd_done;

   assign tick = (cnt_q == CNT_MAX);

   // start/stop resolve the state first; a coincident tick then applies the
   // resulting state's temperature rule in the same cycle.
   always_comb begin
      state_d = state_q;
      cur_w   = {1'b0, cur_q};
      tin_w   = {1'b0, target_temp};
      tgt_w   = {1'b0, tgt_q};
      nxt_w   = cur_w;
      if (stop) begin
         state_d = ST_IDLE;
      end else if (start) begin
         tgt_w   = (tin_w < AMB) ? AMB : (tin_w > TMAX) ? TMAX : tin_w;
         state_d = (cur_w >= tgt_w) ? ST_HOLD : ST_PREHEAT;
      end
      if (tick) begin
         if (state_d == ST_PREHEAT) begin
            nxt_w = (cur_w + RU >= tgt_w) ? tgt_w : cur_w + RU;
            if (nxt_w == tgt_w) state_d = ST_HOLD;
         end else begin
            nxt_w = (cur_w >= AMB + RD) ? cur_w - RD : AMB;
            if (state_d == ST_HOLD && nxt_w + HY <= tgt_w) state_d = ST_PREHEAT;
         end
      end
      tgt_d = tgt_w[9:0];
      cur_d = nxt_w[9:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cur_q   <= AMB[9:0];
         tgt_q   <= AMB[9:0];
         cnt_q   <= '0;
         heat_q  <= 1'b0;
         at_q    <= 1'b0;
         hex_q   <= AMB_BCD;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         cnt_q   <= tick ? '0 : cnt_q + 1'b1;
         heat_q  <= (state_d == ST_PREHEAT);
         at_q    <= (state_d == ST_HOLD);
         if (bcd_done) hex_q <= {d2, d1, d0};
      end
   end

   // Conversion restarts on the same edge that commits a new temperature.
   bin2bcd_seq u_bcd (
      .clk  (clk),
      .rst  (rst),
      .load (cur_d != cur_q),
      .bin  (cur_d),
      .bcd2 (d2),
      .bcd1 (d1),
      .bcd0 (d0),
      .done (bcd_done)
   );

   assign cur_temp = cur_q;
   assign heating  = heat_q;
   assign at_temp  = at_q;
   assign cur_hex2 = hex_q[11:8];
   assign cur_hex1 = hex_q[7:4];
   assign cur_hex0 = hex_q[3:0];

endmodule
